// File: rtl/ps2_key_ctrl.sv
// Pops PS/2 scan-code bytes from the keyboard FIFO, decodes make/break/E0, and tracks the held key and press count.
// One byte per 3 cycles at most; bytes stay in the FIFO until the POP cycle.
module ps2_key_ctrl #(
    parameter int CNT_W         = 8,
    parameter int IGNORE_REPEAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    output logic             nextdata_n,
    input  logic             clr,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [CNT_W-1:0] press_count,
    output logic             press_pulse,
    output logic             rel_pulse,
    output logic             ovf_seen,
    output logic             err_seen
);

    typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             brk_p_q, brk_p_d;
    logic             ext_p_q, ext_p_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic             key_down_q, key_down_d;
    logic [CNT_W-1:0] press_count_q, press_count_d;
    logic             press_pulse_q, press_pulse_d;
    logic             rel_pulse_q, rel_pulse_d;
    logic             ovf_seen_q, ovf_seen_d;
    logic             err_seen_q, err_seen_d;
    logic             same_key;

    // A byte matches the held key only if its extended-prefix state matches too.
    assign same_key = key_down_q && (byte_q == key_code_q) && (ext_p_q == key_ext_q);

    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        brk_p_d       = brk_p_q;
        ext_p_d       = ext_p_q;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_down_d    = key_down_q;
        press_count_d = press_count_q;
        press_pulse_d = 1'b0;
        rel_pulse_d   = 1'b0;
        ovf_seen_d    = ovf_seen_q | overflow;
        err_seen_d    = err_seen_q;
        nextdata_n    = 1'b1;

        case (state_q)
            IDLE: begin
                if (ready) begin
                    byte_d  = data;
                    state_d = POP;
                end
            end
            POP: begin
                nextdata_n = 1'b0;
                state_d    = DECODE;
            end
            DECODE: begin
                state_d = IDLE;
                if (byte_q == 8'hE0) begin
                    ext_p_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_p_d = 1'b1;
                end else if (byte_q == 8'h00 || byte_q == 8'hFF) begin
                    err_seen_d = 1'b1;
                    brk_p_d    = 1'b0;
                    ext_p_d    = 1'b0;
                end else if (brk_p_q) begin
                    if (same_key) begin
                        key_down_d  = 1'b0;
                        rel_pulse_d = 1'b1;
                    end
                    brk_p_d = 1'b0;
                    ext_p_d = 1'b0;
                end else begin
                    if (!(same_key && (IGNORE_REPEAT != 0))) begin
                        key_code_d    = byte_q;
                        key_ext_d     = ext_p_q;
                        key_down_d    = 1'b1;
                        press_count_d = press_count_q + CNT_W'(1);
                        press_pulse_d = 1'b1;
                    end
                    ext_p_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over a same-cycle increment or sticky set.
        if (clr) begin
            press_count_d = '0;
            ovf_seen_d    = 1'b0;
            err_seen_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            byte_q        <= '0;
            brk_p_q       <= 1'b0;
            ext_p_q       <= 1'b0;
            key_code_q    <= '0;
            key_ext_q     <= 1'b0;
            key_down_q    <= 1'b0;
            press_count_q <= '0;
            press_pulse_q <= 1'b0;
            rel_pulse_q   <= 1'b0;
            ovf_seen_q    <= 1'b0;
            err_seen_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            brk_p_q       <= brk_p_d;
            ext_p_q       <= ext_p_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_down_q    <= key_down_d;
            press_count_q <= press_count_d;
            press_pulse_q <= press_pulse_d;
            rel_pulse_q   <= rel_pulse_d;
            ovf_seen_q    <= ovf_seen_d;
            err_seen_q    <= err_seen_d;
        end
    end

    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_down    = key_down_q;
    assign press_count = press_count_q;
    assign press_pulse = press_pulse_q;
    assign rel_pulse   = rel_pulse_q;
    assign ovf_seen    = ovf_seen_q;
    assign err_seen    = err_seen_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a behavioural FIFO feeding scan-code bytes.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       nextdata_n;
    logic       clr;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_down;
    logic [7:0] press_count;
    logic       press_pulse;
    logic       rel_pulse;
    logic       ovf_seen;
    logic       err_seen;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int pops       = 0;
    int pp_cnt     = 0;
    int rp_cnt     = 0;
    logic [7:0] fifo_q[$];
    int pop_cyc[$];

    always #5 clk = ~clk;

    ps2_key_ctrl #(.CNT_W(8), .IGNORE_REPEAT(1)) dut (
        .clk(clk), .reset(reset), .ready(ready), .data(data), .overflow(overflow),
        .nextdata_n(nextdata_n), .clr(clr), .key_code(key_code), .key_ext(key_ext),
        .key_down(key_down), .press_count(press_count), .press_pulse(press_pulse),
        .rel_pulse(rel_pulse), .ovf_seen(ovf_seen), .err_seen(err_seen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One negedge step: the FIFO model pops on a low strobe, and pulses are tallied.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!nextdata_n) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pops++;
            pop_cyc.push_back(cyc);
        end
        if (press_pulse) pp_cnt++;
        if (rel_pulse) rp_cnt++;
        ready = (fifo_q.size() != 0);
        data  = ready ? fifo_q[0] : 8'h00;
    endtask

    task automatic feed(input logic [7:0] b);
        fifo_q.push_back(b);
        ready = 1'b1;
        data  = fifo_q[0];
    endtask

    task automatic drain();
        int n = 0;
        while (fifo_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        if (fifo_q.size() != 0) chk("drain_timeout", 32'(fifo_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; ready = 1'b0; data = 8'h00; overflow = 1'b0; clr = 1'b0;
        tick(); tick();
        chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
        chk("rst_outputs", {key_code, key_ext, key_down, press_count, press_pulse, rel_pulse, ovf_seen, err_seen}, 32'd0);
        reset = 1'b0;
        tick();

        // Single make
        feed(8'h1C); drain();
        chk("make_pops", 32'(pops), 32'd1);
        chk("make_code", 32'(key_code), 32'h1C);
        chk("make_down_ext", {key_down, key_ext}, 32'b10);
        chk("make_count", 32'(press_count), 32'd1);
        chk("make_pulses", 32'(pp_cnt), 32'd1);

        // Typematic repeat then break
        feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C); drain();
        chk("rpt_pops", 32'(pops), 32'd5);
        chk("rpt_count", 32'(press_count), 32'd1);
        chk("rpt_down", 32'(key_down), 32'd0);
        chk("rpt_rel", 32'(rp_cnt), 32'd1);
        chk("rpt_press", 32'(pp_cnt), 32'd1);

        // New key replaces held key; stale break ignored
        feed(8'h20); feed(8'h21); feed(8'hF0); feed(8'h20); drain();
        chk("repl_code", 32'(key_code), 32'h21);
        chk("repl_down", 32'(key_down), 32'd1);
        chk("repl_count", 32'(press_count), 32'd3);
        chk("repl_rel", 32'(rp_cnt), 32'd1);
        feed(8'hF0); feed(8'h21); drain();
        chk("repl_brk_down", 32'(key_down), 32'd0);

        // Extended key
        feed(8'hE0); feed(8'h75); drain();
        chk("ext_code", 32'(key_code), 32'h75);
        chk("ext_flag", {key_down, key_ext}, 32'b11);
        chk("ext_count", 32'(press_count), 32'd4);
        feed(8'hE0); feed(8'hF0); feed(8'h75); drain();
        chk("ext_brk_down", 32'(key_down), 32'd0);
        chk("ext_rel", 32'(rp_cnt), 32'd3);

        // Wrap: 251 alternating makes bring the count to FF
        for (int i = 0; i < 251; i++) feed((i % 2 == 0) ? 8'h10 : 8'h11);
        drain();
        chk("wrap_ff", 32'(press_count), 32'hFF);
        feed(8'h2A); drain();
        chk("wrap_00", 32'(press_count), 32'h00);
        feed(8'h34); drain();
        chk("post_wrap", 32'(press_count), 32'h01);

        // clr lands on the same edge as the press
        feed(8'h33);
        tick(); tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (2) tick();
        chk("clr_press_count", 32'(press_count), 32'h00);
        chk("clr_press_code", 32'(key_code), 32'h33);
        chk("clr_press_pulses", 32'(pp_cnt), 32'd258);

        // Sticky overflow
        overflow = 1'b1; tick(); overflow = 1'b0; repeat (4) tick();
        chk("ovf_sticky", 32'(ovf_seen), 32'd1);

        // Error byte clears a pending break prefix
        feed(8'hF0); feed(8'hFF); feed(8'h44); drain();
        chk("err_seen", 32'(err_seen), 32'd1);
        chk("err_make_code", 32'(key_code), 32'h44);
        chk("err_make_count", 32'(press_count), 32'd1);

        clr = 1'b1; tick(); clr = 1'b0; tick();
        chk("clr_status", {ovf_seen, err_seen}, 32'b00);
        chk("clr_count", 32'(press_count), 32'd0);
        chk("clr_keeps_key", {key_code, key_down}, {8'h44, 1'b1});

        // Eight queued bytes: one pop every 3 cycles
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) feed(8'h50 + 8'(i));
        drain();
        chk("b2b_pops", 32'(pop_cyc.size()), 32'd8);
        for (int i = 1; i < 8 && i < pop_cyc.size(); i++)
            chk("b2b_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd3);
        chk("b2b_count", 32'(press_count), 32'd8);
        chk("b2b_code", 32'(key_code), 32'h57);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
